// File: rtl/aes128_ecb_decryptor.sv
// Iterative AES-128 ECB inverse cipher: one round per clock, on-the-fly reverse key
// schedule, and a one-entry cache of the round-10 key so a repeated key skips expansion.
package aes128_ecb_decryptor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Byte i of the state is row i%4, column i/4; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

module aes128_dec_sbox
  import aes128_ecb_decryptor_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = fwd_affine(gf_inv(a));
endmodule

module aes128_dec_inv_sbox
  import aes128_ecb_decryptor_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = gf_inv(inv_affine(a));
endmodule

module aes128_ecb_decryptor
  import aes128_ecb_decryptor_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] cipher_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_text,
  output logic         busy
);

  state_t       state_r, state_nxt_s;
  logic [127:0] blk_r, rk_r, rk10_r, ct_r, key0_r, plain_text_r;
  logic         cache_vld_r, out_valid_r;
  logic [3:0]   rnd_r;

  logic         acc_s, hit_s;
  logic [7:0]   rc_s;
  logic [31:0]  sb_in_s, rot_s, sub_s, rcw_s;
  logic [31:0]  w4_s, w5_s, w6_s, w7_s;
  logic [127:0] fwd_rk_s, inv_rk_s, isr_s, isb_s, ark_s, imc_s;

  assign acc_s = in_valid && (state_r == IDLE);
  assign hit_s = cache_vld_r && (key == key0_r);

  // The forward and reverse schedules share one SubWord: w3 when expanding, w7^w6 when reversing.
  assign rc_s    = rcon(rnd_r + 4'd1);
  assign rcw_s   = {rc_s, 24'h000000};
  assign sb_in_s = (state_r == KEXP) ? rk_r[31:0] : (rk_r[31:0] ^ rk_r[63:32]);
  assign rot_s   = {sb_in_s[23:0], sb_in_s[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_kbox
    aes128_dec_sbox u_sbox (.a(rot_s[31-8*i -: 8]), .y(sub_s[31-8*i -: 8]));
  end

  assign w4_s     = rk_r[127:96] ^ sub_s ^ rcw_s;
  assign w5_s     = rk_r[95:64] ^ w4_s;
  assign w6_s     = rk_r[63:32] ^ w5_s;
  assign w7_s     = rk_r[31:0] ^ w6_s;
  assign fwd_rk_s = {w4_s, w5_s, w6_s, w7_s};
  assign inv_rk_s = {rk_r[127:96] ^ sub_s ^ rcw_s,
                     rk_r[95:64] ^ rk_r[127:96],
                     rk_r[63:32] ^ rk_r[95:64],
                     rk_r[31:0] ^ rk_r[63:32]};

  assign isr_s = inv_shift_rows(blk_r);

  for (genvar i = 0; i < 16; i++) begin : g_ibox
    aes128_dec_inv_sbox u_ibox (.a(isr_s[127-8*i -: 8]), .y(isb_s[127-8*i -: 8]));
  end

  assign ark_s = isb_s ^ inv_rk_s;
  assign imc_s = inv_mix_columns(ark_s);

  assign in_ready   = (state_r == IDLE) && !rst;
  assign busy       = (state_r == KEXP) || (state_r == ROUND) || (state_r == FINAL);
  assign out_valid  = out_valid_r;
  assign plain_text = plain_text_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (acc_s) state_nxt_s = hit_s ? ROUND : KEXP;
        else       state_nxt_s = IDLE;
      end
      KEXP: begin
        if (rnd_r == 4'd9) state_nxt_s = ROUND;
        else               state_nxt_s = KEXP;
      end
      ROUND: begin
        if (rnd_r == 4'd1) state_nxt_s = FINAL;
        else               state_nxt_s = ROUND;
      end
      FINAL:   state_nxt_s = DONE;
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath, key cache and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_r        <= 128'h0;
      rk_r         <= 128'h0;
      rk10_r       <= 128'h0;
      ct_r         <= 128'h0;
      key0_r       <= 128'h0;
      plain_text_r <= 128'h0;
      cache_vld_r  <= 1'b0;
      out_valid_r  <= 1'b0;
      rnd_r        <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            ct_r   <= cipher_text;
            key0_r <= key;
            if (hit_s) begin
              rk_r  <= rk10_r;
              blk_r <= cipher_text ^ rk10_r;
              rnd_r <= 4'd9;
            end else begin
              rk_r  <= key;
              rnd_r <= 4'd0;
            end
          end
        end
        KEXP: begin
          rk_r <= fwd_rk_s;
          if (rnd_r == 4'd9) begin
            rk10_r      <= fwd_rk_s;
            blk_r       <= ct_r ^ fwd_rk_s;
            cache_vld_r <= 1'b1;
          end else begin
            rnd_r <= rnd_r + 4'd1;
          end
        end
        ROUND: begin
          rk_r  <= inv_rk_s;
          blk_r <= imc_s;
          rnd_r <= rnd_r - 4'd1;
        end
        FINAL: begin
          blk_r        <= ark_s;
          plain_text_r <= ark_s;
          out_valid_r  <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_ecb_decryptor.sv
// Directed bench for aes128_ecb_decryptor: FIPS-197 vectors, cache hit/miss latency,
// backpressure, mid-run reset, and loopback through a table-based encryption model.
module tb_aes128_ecb_decryptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key = 128'h0;
  logic [127:0] cipher_text = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] plain_text;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb_t [256];
  int         exp_t [256];
  int         log_t [256];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_ecb_decryptor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key),
    .cipher_text(cipher_text), .out_valid(out_valid), .out_ready(out_ready),
    .plain_text(plain_text), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box via exp/log tables over generator 03, then the affine map bit by bit.
  task automatic build_tables();
    logic [7:0] e, v, s, c;
    e = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = int'(e);
      log_t[e] = i;
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      v = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255][7:0];
      for (int b = 0; b < 8; b++)
        s[b] = v[b] ^ v[(b+4)%8] ^ v[(b+5)%8] ^ v[(b+6)%8] ^ v[(b+7)%8] ^ c[b];
      sb_t[x] = s;
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] s, o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]], sb_t[t[31:24]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = p ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb_t[s[127-8*i -: 8]];
      o = 128'h0;
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          o[127-8*(q+4*c) -: 8] = s[127-8*(q+4*((c+q)%4)) -: 8];
      s = o;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One job: accept, scramble inputs, measure latency (E0 counted), optional backpressure, consume.
  task automatic run_job(input string tag, input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] exp_pt, input int exp_lat, input int hold);
    int cnt;
    int bad;
    cnt = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_ready"}, 128'(in_ready), 128'(1));
    in_valid    = 1'b1;
    key         = k;
    cipher_text = c;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    key         = rnd128();
    cipher_text = rnd128();
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, "_lat"}, 128'(cnt + 1), 128'(exp_lat));
    chk({tag, "_pt"}, plain_text, exp_pt);
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid    = 1'b1;
        cipher_text = rnd128();
        @(posedge clk);
        #1;
        if (plain_text !== exp_pt || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      chk({tag, "_hold"}, 128'(bad), 128'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, 128'(out_valid), 128'(0));
    if (hold > 0) begin
      chk({tag, "_rdy_after"}, 128'(in_ready), 128'(1));
      chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    int bad;
    logic [127:0] rk, rp;
    build_tables();
    chk("model_c1", enc(K1, P1), C1);
    chk("model_b", enc(K2, P2), C2);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_plain", plain_text, 128'h0);
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'(1));

    run_job("c1_miss", K1, C1, P1, 21, 0);
    run_job("b_miss", K2, C2, P2, 21, 0);
    run_job("b_hit", K2, C2, P2, 11, 0);
    run_job("b_bp", K2, C2, P2, 11, 50);

    // Reset during key expansion (cache holds K2, so K1 is a miss).
    @(negedge clk);
    in_valid = 1'b1; key = K1; cipher_text = C1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("kexp_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", 128'(in_ready), 128'(1));
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    chk("no_output_after_rst", 128'(bad), 128'(0));
    run_job("c1_after_rst", K1, C1, P1, 21, 0);
    run_job("c1_hit", K1, C1, P1, 11, 0);

    // Idle reset must invalidate the cache.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_job("c1_cache_clr", K1, C1, P1, 21, 0);

    run_job("alt_a", K2, C2, P2, 21, 0);
    run_job("alt_b", K1, C1, P1, 21, 0);
    run_job("alt_a2", K2, C2, P2, 21, 0);

    for (int n = 0; n < 1000; n++) begin
      rk = rnd128();
      rp = rnd128();
      run_job("loop", rk, enc(rk, rp), rp, 21, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
